// File: rtl/sdp_core_y_dpsplit_pkg.sv
// sdp_core_y_dpsplit_pkg: shared SDP Y-path data-path widths and split-FSM state type
package sdp_core_y_dpsplit_pkg;
    localparam int SDP_DP_IW    = 512;
    localparam int SDP_DP_OW    = 128;
    localparam int SDP_DP_RATIO = SDP_DP_IW / SDP_DP_OW;
    localparam int SDP_DP_CNT_W = $clog2(SDP_DP_RATIO);
    typedef enum logic {ST_EMPTY = 1'b0, ST_SEND = 1'b1} dpsplit_state_e;
endpackage

// File: rtl/sdp_core_y_dpsplit.sv
// sdp_core_y_dpsplit: splits a 512-bit Y-path beat into up to four 128-bit segments, LS first.
// Ports: nvdla_core_clk/nvdla_core_rstn (async active-low); inp_* = wide beat in with
// segment count minus one (inp_nseg); out_* = one segment per cycle, out_last on the final one.
module sdp_core_y_dpsplit
    import sdp_core_y_dpsplit_pkg::*;
#(
    parameter int IW    = SDP_DP_IW,
    parameter int OW    = SDP_DP_OW,
    parameter int CNT_W = SDP_DP_CNT_W
) (
    input  logic             nvdla_core_clk,
    input  logic             nvdla_core_rstn,
    input  logic             inp_pvld,
    output logic             inp_prdy,
    input  logic [IW-1:0]    inp_data,
    input  logic [CNT_W-1:0] inp_nseg,
    output logic             out_pvld,
    input  logic             out_prdy,
    output logic [OW-1:0]    out_data,
    output logic             out_last
);
    localparam int RATIO = IW / OW;
    dpsplit_state_e   r_state, w_next_state;
    logic [IW-1:0]    r_hold_data;
    logic [CNT_W-1:0] r_hold_nseg;
    logic [CNT_W-1:0] r_seg_cnt;
    logic [CNT_W-1:0] w_next_cnt;
    logic             w_hold_vld;
    logic             w_inp_acc;
    logic             w_out_acc;
    logic [OW-1:0]    w_segs [RATIO];
    genvar g;
    generate
        for (g = 0; g < RATIO; g++) begin : g_seg
            assign w_segs[g] = r_hold_data[OW*g +: OW];
        end
    endgenerate
    always_comb begin
        w_hold_vld = (r_state == ST_SEND);
        out_pvld   = w_hold_vld;
        out_last   = w_hold_vld & (r_seg_cnt == r_hold_nseg);
        out_data   = w_segs[r_seg_cnt];
        // Ready is a function of held state and out_prdy only, so the last segment
        // and the next beat's acceptance can share a cycle.
        inp_prdy   = !w_hold_vld | (out_prdy & out_last);
        w_inp_acc  = inp_pvld & inp_prdy;
        w_out_acc  = out_pvld & out_prdy;
        w_next_state = (r_state == ST_EMPTY) ? (w_inp_acc ? ST_SEND : ST_EMPTY)
                     : ((w_out_acc & out_last & !w_inp_acc) ? ST_EMPTY : ST_SEND);
        w_next_cnt = w_inp_acc                ? '0
                   : (w_out_acc & !out_last)  ? r_seg_cnt + 1'b1
                   : (w_out_acc & out_last)   ? '0
                   : r_seg_cnt;
    end
    always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn) begin
        if (!nvdla_core_rstn) begin
            r_state     <= ST_EMPTY;
            r_hold_nseg <= '0;
            r_seg_cnt   <= '0;
        end else begin
            r_state     <= w_next_state;
            r_seg_cnt   <= w_next_cnt;
            if (w_inp_acc) r_hold_nseg <= inp_nseg;
        end
    end
    // Payload register carries no reset; it is only observed while out_pvld is high.
    always_ff @(posedge nvdla_core_clk) begin
        if (w_inp_acc) r_hold_data <= inp_data;
    end
endmodule

// File: tb/tb_sdp_core_y_dpsplit.sv
// tb_sdp_core_y_dpsplit: table-driven directed vectors, reset corner case and random scoreboard
module tb_sdp_core_y_dpsplit;
    logic         clk = 1'b0;
    logic         rstn = 1'b0;
    logic         inp_pvld = 1'b0;
    logic         inp_prdy;
    logic [511:0] inp_data = '0;
    logic [1:0]   inp_nseg = '0;
    logic         out_pvld;
    logic         out_prdy = 1'b0;
    logic [127:0] out_data;
    logic         out_last;
    int n_pass = 0;
    int n_total = 0;
    sdp_core_y_dpsplit dut (
        .nvdla_core_clk(clk), .nvdla_core_rstn(rstn),
        .inp_pvld(inp_pvld), .inp_prdy(inp_prdy), .inp_data(inp_data), .inp_nseg(inp_nseg),
        .out_pvld(out_pvld), .out_prdy(out_prdy), .out_data(out_data), .out_last(out_last)
    );
    initial forever #5 clk = ~clk;
    typedef struct {
        logic       pvld; logic prdy; logic [1:0] nseg; logic [7:0] tag;
        logic       e_pvld; logic e_last; logic e_iprdy; logic e_chk; logic [7:0] e_tag; int e_k;
    } vec_t;
    typedef struct { logic [127:0] d; logic l; } seg_t;
    vec_t tbl[$];
    seg_t q[$];
    function automatic logic [127:0] seg(input logic [7:0] tag, input int k);
        logic [3:0] k4 = 4'(k);
        logic [7:0] k8 = 8'(k);
        return (tag == 8'd0) ? {32{k4}} : {8{tag, k8}};
    endfunction
    function automatic logic [511:0] beat(input logic [7:0] tag);
        return {seg(tag, 3), seg(tag, 2), seg(tag, 1), seg(tag, 0)};
    endfunction
    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_total++;
        if (act !== exp) $display("FAIL %s: got %h expected %h", name, act, exp);
        else n_pass++;
    endtask
    task automatic step();
        @(posedge clk);
        #1;
    endtask
    task automatic add(input logic pv, pr, input logic [1:0] ns, input logic [7:0] tg,
                       input logic ev, el, ei, ec, input logic [7:0] et, input int ek);
        tbl.push_back('{pv, pr, ns, tg, ev, el, ei, ec, et, ek});
    endtask
    initial begin
        // single nseg=3 beat, segments 0..3 then empty
        add(1,1,3,8'h00, 0,0,1,0,8'h00,0);
        add(0,1,0,8'h00, 1,0,0,1,8'h00,0);
        add(0,1,0,8'h00, 1,0,0,1,8'h00,1);
        add(0,1,0,8'h00, 1,0,0,1,8'h00,2);
        add(0,1,0,8'h00, 1,1,1,1,8'h00,3);
        // back-to-back nseg=0 beats A, B, C
        add(1,1,0,8'hA1, 0,0,1,0,8'h00,0);
        add(1,1,0,8'hB2, 1,1,1,1,8'hA1,0);
        add(1,1,0,8'hC3, 1,1,1,1,8'hB2,0);
        add(0,1,3,8'h00, 1,1,1,1,8'hC3,0);
        add(0,1,0,8'h00, 0,0,1,0,8'h00,0);
        // nseg=1 beat with out_prdy 1,0,0,1
        add(1,1,1,8'hD4, 0,0,1,0,8'h00,0);
        add(0,1,0,8'h00, 1,0,0,1,8'hD4,0);
        add(0,0,0,8'h00, 1,1,0,1,8'hD4,1);
        add(0,0,0,8'h00, 1,1,0,1,8'hD4,1);
        add(0,1,0,8'h00, 1,1,1,1,8'hD4,1);
        add(0,1,0,8'h00, 0,0,1,0,8'h00,0);
        // three nseg=3 beats with inp_pvld held: accepts on rows 0, 4, 8
        add(1,1,3,8'hE5, 0,0,1,0,8'h00,0);
        for (int k = 0; k < 4; k++) add(1,1,3,8'hF6, 1,k==3,k==3,1,8'hE5,k);
        for (int k = 0; k < 4; k++) add(1,1,3,8'h97, 1,k==3,k==3,1,8'hF6,k);
        for (int k = 0; k < 4; k++) add(0,1,0,8'h00, 1,k==3,k==3,1,8'h97,k);
        add(0,1,0,8'h00, 0,0,1,0,8'h00,0);

        step();
        @(negedge clk);
        chk("rst_out_pvld", 128'(out_pvld), 128'd0);
        chk("rst_out_last", 128'(out_last), 128'd0);
        chk("rst_inp_prdy", 128'(inp_prdy), 128'd1);
        step();
        rstn = 1'b1;
        foreach (tbl[i]) begin
            inp_pvld = tbl[i].pvld;
            out_prdy = tbl[i].prdy;
            inp_nseg = tbl[i].nseg;
            inp_data = beat(tbl[i].tag);
            @(negedge clk);
            chk($sformatf("row%0d_out_pvld", i), 128'(out_pvld), 128'(tbl[i].e_pvld));
            chk($sformatf("row%0d_out_last", i), 128'(out_last), 128'(tbl[i].e_last));
            chk($sformatf("row%0d_inp_prdy", i), 128'(inp_prdy), 128'(tbl[i].e_iprdy));
            if (tbl[i].e_chk) chk($sformatf("row%0d_out_data", i), out_data, seg(tbl[i].e_tag, tbl[i].e_k));
            step();
        end

        // reset asserted after segment 1 of an nseg=3 beat
        inp_pvld = 1; inp_nseg = 3; inp_data = beat(8'h11); out_prdy = 1;
        step();
        inp_pvld = 0; inp_nseg = 0; inp_data = '0;
        @(negedge clk);
        chk("mr_seg0", out_data, seg(8'h11, 0));
        step();
        @(negedge clk);
        chk("mr_seg1", out_data, seg(8'h11, 1));
        step();
        #1;
        rstn = 1'b0;
        #1;
        chk("mr_async_pvld", 128'(out_pvld), 128'd0);
        chk("mr_async_prdy", 128'(inp_prdy), 128'd1);
        step();
        rstn = 1'b1;
        @(negedge clk);
        chk("mr_after_pvld", 128'(out_pvld), 128'd0);
        step();
        inp_pvld = 1; inp_nseg = 1; inp_data = beat(8'h22);
        step();
        inp_pvld = 0; inp_nseg = 3;
        @(negedge clk);
        chk("mr_new_seg0", out_data, seg(8'h22, 0));
        chk("mr_new_last0", 128'(out_last), 128'd0);
        step();
        @(negedge clk);
        chk("mr_new_seg1", out_data, seg(8'h22, 1));
        chk("mr_new_last1", 128'(out_last), 128'd1);
        step();
        @(negedge clk);
        chk("mr_new_empty", 128'(out_pvld), 128'd0);
        step();

        // randomized traffic against a queue-of-segments model
        begin
            int beats_gen = 0, beats_acc = 0, n_last = 0, cyc = 0;
            logic pend = 0;
            logic [511:0] pdata = '0;
            logic [1:0] pn = '0;
            logic exp_iprdy, ia, oa;
            q.delete();
            while (beats_acc < 1000 || q.size() != 0) begin
                if (!pend && beats_gen < 1000 && ($urandom_range(3) != 0)) begin
                    for (int w = 0; w < 16; w++) pdata[32*w +: 32] = $urandom;
                    pn = 2'($urandom_range(3));
                    pend = 1;
                    beats_gen++;
                end
                inp_pvld = pend;
                inp_data = pend ? pdata : '1;
                inp_nseg = pend ? pn : 2'($urandom_range(3));
                out_prdy = ($urandom_range(9) < 7);
                @(negedge clk);
                exp_iprdy = (q.size() == 0) || (out_prdy && q.size() == 1);
                chk("rnd_inp_prdy", 128'(inp_prdy), 128'(exp_iprdy));
                chk("rnd_out_pvld", 128'(out_pvld), 128'(q.size() != 0));
                if (q.size() != 0) begin
                    chk("rnd_out_data", out_data, q[0].d);
                    chk("rnd_out_last", 128'(out_last), 128'(q[0].l));
                end
                oa = (q.size() != 0) && out_prdy;
                ia = pend && exp_iprdy;
                if (oa) begin
                    if (q[0].l && out_last) n_last++;
                    void'(q.pop_front());
                end
                if (ia) begin
                    for (int k = 0; k <= int'(pn); k++) q.push_back('{pdata[128*k +: 128], k == int'(pn)});
                    pend = 0;
                    beats_acc++;
                end
                step();
                cyc++;
                if (cyc > 40000) begin
                    chk("rnd_timeout", 128'(cyc), 128'd0);
                    break;
                end
            end
            chk("rnd_last_count", 128'(n_last), 128'd1000);
            chk("rnd_beat_count", 128'(beats_acc), 128'd1000);
        end
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule

// File: doc/sdp_core_y_dpsplit.md
# sdp_core_y_dpsplit

- Splits each 512-bit SDP Y-path beat into up to four 128-bit segments and emits them one per cycle, least-significant segment first.
- It is the inverse of the Y-path 128→512 packer: it sits on the return path where wide DMA-read data feeds the 128-bit Y-core pipeline.
- A per-beat segment count supports short final beats, and `out_last` marks the final segment of each beat.

## Interface
Parameters:
- `IW`, 512: input beat width.
- `OW`, 128: output segment width.
- `RATIO`, IW/OW = 4: derived value, not overridable.
- `CNT_W`, 2: segment-counter width, equal to log2(RATIO).

Ports:
- `nvdla_core_clk`  in  1  Single clock; all state changes on its rising edge.
- `nvdla_core_rstn`  in  1  Reset, asynchronous, active-low.
- `inp_pvld`  in  1  Input beat valid.
- `inp_prdy`  out  1  Input beat ready.
- `inp_data`  in  IW  Input beat; segment k is `inp_data[OW*k +: OW]`.
- `inp_nseg`  in  CNT_W  Number of valid segments minus 1 (0 to 3); sampled with the beat.
- `out_pvld`  out  1  Output segment valid.
- `out_prdy`  in  1  Output segment ready.
- `out_data`  out  OW  Current segment.
- `out_last`  out  1  Current segment is the last valid segment of its beat.

## Operation
- State:
  - `hold_vld`, a 1-bit flag.
  - `hold_data`, IW bits, with no reset.
  - `hold_nseg`, CNT_W bits.
  - `seg_cnt`, CNT_W bits.
- Handshakes:
  - Input accept: `inp_acc = inp_pvld & inp_prdy`.
  - Output accept: `out_acc = out_pvld & out_prdy`.
- `inp_prdy = !hold_vld | (out_prdy & out_last)`. This is combinational and depends only on registers and `out_prdy`, never on `inp_pvld`.
- On `inp_acc`:
  - `hold_data <= inp_data`, `hold_nseg <= inp_nseg`, `seg_cnt <= 0`, `hold_vld <= 1`.
- On `out_acc & !out_last`: `seg_cnt <= seg_cnt + 1`.
- On `out_acc & out_last & !inp_acc`: `hold_vld <= 0`, `seg_cnt <= 0`.
- Outputs:
  - `out_pvld = hold_vld`.
  - `out_data = hold_data[OW*seg_cnt +: OW]`.
  - `out_last = hold_vld & (seg_cnt == hold_nseg)`.
- `seg_cnt` never exceeds `hold_nseg`. Segments above `hold_nseg` are never emitted.
- Equivalent 2-state view:
  - States are EMPTY (`hold_vld`=0) and SEND.
  - EMPTY→SEND on `inp_acc`.
  - SEND→SEND on non-last `out_acc`, or on last `out_acc` together with `inp_acc`.
  - SEND→EMPTY on last `out_acc` without `inp_acc`.

## Timing
- Reset values: `out_pvld`=0, `out_last`=0, `inp_prdy`=1, `seg_cnt`=0, `hold_nseg`=0. `out_data` is don't-care while `out_pvld`=0.
- Latency: a beat accepted at edge N presents segment 0 from cycle N+1.
- Throughput: a beat with nseg=n occupies n+1 output cycles. The last segment and the next beat's acceptance share a cycle, so there are no bubbles between beats.
- Stall: while `out_pvld & !out_prdy`, `out_data` and `out_last` hold stable and `inp_prdy`=0.
- nseg=0: a single output beat with `out_last`=1. Back-to-back nseg=0 beats sustain one beat per cycle.
- Reset asserted mid-beat: all remaining segments are discarded and `out_pvld` drops asynchronously. After release the block is EMPTY.
- `inp_nseg` is ignored when `inp_pvld`=0.

## Structure
- Shared SDP package holds `SDP_DP_IW`, `SDP_DP_OW`, `SDP_DP_RATIO` and `SDP_DP_CNT_W`. The same constants are used by the Y-path packer, so pack and split widths cannot diverge.
- No sub-module. The segment mux, counter and hold register are implemented inline.
- The module is a single register stage with no FIFO.

## Test plan
- Reset, then one beat with `inp_data` = {128'h3…3, 128'h2…2, 128'h1…1, 128'h0…0}, nseg=3, and `out_prdy`=1 constantly.
  - Required: segments 0,1,2,3 on cycles N+1 to N+4.
  - Required: `out_last` only on segment 3.
  - Required: `inp_prdy` high again on cycle N+4.
- Three consecutive nseg=3 beats with `inp_pvld` held and `out_prdy`=1.
  - Required: 12 contiguous `out_pvld` cycles with no gap.
  - Required: `inp_acc` on cycles 0, 4 and 8.
- nseg=0 beats back-to-back (A, B, C).
  - Required: one output per cycle, each with `out_last`=1.
  - Required: only segment 0 of each beat appears.
- nseg=1 beat with `out_prdy` toggling 1,0,0,1.
  - Required: segment 0 is accepted, then segment 1 is held stable for 2 cycles and accepted.
  - Required: `inp_prdy`=0 during the stall.
- Assert `nvdla_core_rstn` low after segment 1 of an nseg=3 beat.
  - Required: `out_pvld` goes to 0 immediately.
  - Required: after release, the next beat starts at segment 0 and no stale segment 2/3 is emitted.
- Randomized `inp_pvld`/`out_prdy`, 1000 beats with random nseg.
  - Required: a scoreboard concatenation of the outputs matches the input segments 0..nseg in order.
  - Required: `out_last` count equals the beat count.
